// File: rtl/change_dispenser.sv
// Greedy change dispenser: presents the largest usable coin until the balance is paid or stuck.
// First coin is offered the cycle after start; a coin is held while i_coin_ready is low.
module change_dispenser #(
  parameter int kNumCoins    = 3,
  parameter int kTotalBits   = 31,
  parameter int COIN_VALUE_0 = 100,
  parameter int COIN_VALUE_1 = 500,
  parameter int COIN_VALUE_2 = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [kTotalBits-1:0] i_balance,
  input  logic [kNumCoins-1:0]  i_coin_empty,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_busy,
  output logic [kTotalBits-1:0] o_remaining,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_residual
);

  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

  state_t                state_q, state_d;
  logic [kTotalBits-1:0] remaining_q, remaining_d;
  logic [kTotalBits-1:0] residual_q, residual_d;

  logic                  sel_found;
  logic [kNumCoins-1:0]  sel_coin;
  logic [kTotalBits-1:0] sel_value;

  function automatic logic [kTotalBits-1:0] coin_value(input int idx);
    case (idx)
      0:       return kTotalBits'(COIN_VALUE_0);
      1:       return kTotalBits'(COIN_VALUE_1);
      2:       return kTotalBits'(COIN_VALUE_2);
      default: return '1;
    endcase
  endfunction

  // Ascending scan: the last usable match is the highest-value coin that fits.
  always_comb begin
    sel_found = 1'b0;
    sel_coin  = '0;
    sel_value = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i < 3 && !i_coin_empty[i] && coin_value(i) <= remaining_q) begin
        sel_found   = 1'b1;
        sel_coin    = '0;
        sel_coin[i] = 1'b1;
        sel_value   = coin_value(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    residual_d    = residual_q;
    o_coin_valid  = 1'b0;
    o_return_coin = '0;
    o_done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          remaining_d = i_balance;
          residual_d  = '0;
          state_d     = DISPENSE;
        end
      end
      DISPENSE: begin
        if (sel_found) begin
          o_coin_valid  = 1'b1;
          o_return_coin = sel_coin;
          if (i_coin_ready) remaining_d = remaining_q - sel_value;
        end else begin
          residual_d = remaining_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        remaining_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      residual_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residual_q  <= residual_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_remaining = remaining_q;
  assign o_residual  = residual_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coins queued at start, popped on each transfer.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [30:0] i_balance;
  logic [2:0]  i_coin_empty;
  logic        i_coin_ready;
  logic        o_coin_valid;
  logic [2:0]  o_return_coin;
  logic        o_busy;
  logic [30:0] o_remaining;
  logic        o_done;
  logic [30:0] o_residual;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  change_dispenser dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_balance    (i_balance),
    .i_coin_empty (i_coin_empty),
    .i_coin_ready (i_coin_ready),
    .o_coin_valid (o_coin_valid),
    .o_return_coin(o_return_coin),
    .o_busy       (o_busy),
    .o_remaining  (o_remaining),
    .o_done       (o_done),
    .o_residual   (o_residual)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int val_of(input logic [2:0] oh);
    case (oh)
      3'b001:  return 100;
      3'b010:  return 500;
      3'b100:  return 1000;
      default: return 0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_coin_valid), 0);
    chk({tag, "_coin"}, 32'(o_return_coin), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_remaining"}, 32'(o_remaining), 0);
  endtask

  // Expected coins must already be in exp_q; i_start stays high during the job to prove it is ignored.
  task automatic run_job(input string tag, input int bal, input logic [2:0] empty,
                         input int ready_delay, input int exp_res);
    int n_exp, cycles, stall, model_rem, exp_cycles;
    logic xfer;
    logic [2:0] c;
    n_exp = exp_q.size();
    model_rem = bal;
    stall = 0;
    cycles = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_balance = 31'(bal);
    i_coin_empty = empty;
    i_coin_ready = 1'b1;
    @(posedge clk); #1;
    i_balance = 31'h7fff_ffff;
    chk({tag, "_busy_start"}, 32'(o_busy), 1);
    while (!o_done && cycles < 100) begin
      xfer = 1'b0;
      i_coin_ready = 1'b1;
      if (o_coin_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected_coin"}, 32'(o_return_coin), 0);
        end else begin
          chk({tag, "_coin"}, 32'(o_return_coin), 32'(exp_q[0]));
          chk({tag, "_remaining"}, 32'(o_remaining), 32'(model_rem));
        end
        i_coin_ready = (stall >= ready_delay);
        if (!i_coin_ready) stall++;
        xfer = i_coin_ready;
      end
      @(posedge clk); #1;
      cycles++;
      if (xfer && exp_q.size() > 0) begin
        c = exp_q.pop_front();
        model_rem -= val_of(c);
      end
    end
    i_start = 1'b0;
    chk({tag, "_done_seen"}, 32'(o_done), 1);
    exp_cycles = (n_exp > 0) ? n_exp + ready_delay + 1 : 1;
    chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    chk({tag, "_coins_left"}, 32'(exp_q.size()), 0);
    chk({tag, "_residual"}, 32'(o_residual), 32'(exp_res));
    chk({tag, "_busy_done"}, 32'(o_busy), 1);
    chk({tag, "_valid_done"}, 32'(o_coin_valid), 0);
    exp_q.delete();
    @(posedge clk); #1;
    check_idle_outputs({tag, "_after"});
    chk({tag, "_residual_held"}, 32'(o_residual), 32'(exp_res));
  endtask

  task automatic model_job(input int bal, input logic [2:0] empty, output int res);
    int rem, pick;
    int val[3] = '{100, 500, 1000};
    logic [2:0] oh;
    rem = bal;
    forever begin
      pick = -1;
      for (int i = 2; i >= 0; i--)
        if (pick < 0 && !empty[i] && val[i] <= rem) pick = i;
      if (pick < 0) break;
      oh = 3'b001 << pick;
      exp_q.push_back(oh);
      rem -= val[pick];
    end
    res = rem;
  endtask

  initial begin
    int res, bal, dly;
    logic [2:0] emp;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_balance = '0;
    i_coin_empty = '0;
    i_coin_ready = 1'b0;
    #3;
    check_idle_outputs("reset");
    chk("reset_residual", 32'(o_residual), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    exp_q.push_back(3'b100); exp_q.push_back(3'b010);
    exp_q.push_back(3'b001); exp_q.push_back(3'b001);
    run_job("b1700", 1700, 3'b000, 0, 0);

    exp_q.push_back(3'b100);
    run_job("b1000_stall", 1000, 3'b000, 3, 0);

    run_job("b0", 0, 3'b000, 0, 0);

    exp_q.push_back(3'b001);
    run_job("b150", 150, 3'b000, 0, 50);

    exp_q.push_back(3'b010); exp_q.push_back(3'b010);
    run_job("b1000_no1000", 1000, 3'b100, 0, 0);

    run_job("b1000_all_empty", 1000, 3'b111, 0, 1000);

    // Reset in the middle of a job.
    @(negedge clk);
    i_start = 1'b1; i_balance = 31'd1700; i_coin_empty = '0; i_coin_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("rst_first_coin", 32'(o_return_coin), 32'(3'b100));
    @(posedge clk); #1;
    chk("rst_after_xfer_rem", 32'(o_remaining), 700);
    chk("rst_second_coin", 32'(o_return_coin), 32'(3'b010));
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    chk("rst_async_residual", 32'(o_residual), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_no_done", 32'(o_done), 0);
    end
    reset_n = 1'b1;
    exp_q.push_back(3'b010);
    run_job("post_rst_500", 500, 3'b000, 0, 0);

    for (int r = 0; r < 8; r++) begin
      bal = $urandom_range(0, 40) * 50;
      emp = 3'($urandom_range(0, 7));
      dly = $urandom_range(0, 2);
      model_job(bal, emp, res);
      if (exp_q.size() == 0) dly = 0;
      run_job($sformatf("rand%0d", r), bal, emp, dly, res);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter kNumCoins, default 3, number of coin denominations.
REQ-002 Parameter kTotalBits, default 31, width of balance values.
REQ-003 Parameters COIN_VALUE_0/1/2, defaults 100/500/1000, coin values in strictly ascending index order.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  request to dispense change for i_balance.
REQ-007 i_balance  input  kTotalBits  balance to return, sampled on accepted start.
REQ-008 i_coin_empty  input  kNumCoins  bit i high: denomination i tube empty, unusable.
REQ-009 i_coin_ready  input  1  coin mechanism accepts the presented coin this cycle.
REQ-010 o_coin_valid  output  1  a coin is being presented.
REQ-011 o_return_coin  output  kNumCoins  one-hot coin being presented; zero when o_coin_valid low.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_remaining  output  kTotalBits  balance still owed.
REQ-014 o_done  output  1  one-cycle pulse at end of a dispense job.
REQ-015 o_residual  output  kTotalBits  undispensable remainder of the last job, held until next accepted start.

Function
REQ-016 FSM states SHALL be IDLE, DISPENSE, DONE.
REQ-017 IDLE: i_start high at edge SHALL latch i_balance into remaining, clear o_residual, enter DISPENSE.
REQ-018 i_start SHALL be ignored in DISPENSE and DONE; no queuing.
REQ-019 DISPENSE: selected coin SHALL be the highest index i with COIN_VALUE_i <= remaining and i_coin_empty[i] low.
REQ-020 With a coin selected, o_coin_valid SHALL be 1 and o_return_coin SHALL be its one-hot; outputs combinational from state, remaining, i_coin_empty.
REQ-021 Coin transfer occurs only on edge with o_coin_valid and i_coin_ready both high; remaining SHALL then decrease by that coin's value.
REQ-022 While i_coin_ready low, remaining SHALL hold; o_return_coin may change only if i_coin_empty changes.
REQ-023 No coin selectable (remaining zero, below smallest usable value, or all usable tubes empty): next edge SHALL enter DONE and load o_residual with remaining.
REQ-024 DONE: o_done SHALL be 1 for exactly that cycle; next edge returns to IDLE; remaining SHALL be zero on entering IDLE.
REQ-025 Latency: start accepted at edge t -> first o_coin_valid in cycle after t; minimum job (i_balance 0) -> o_done in second cycle after t.
REQ-026 Arithmetic SHALL be unsigned kTotalBits; remaining never underflows, guaranteed by REQ-019.
REQ-027 o_return_coin SHALL never have more than one bit set.
REQ-028 o_remaining SHALL reflect the registered remaining value in all states.

Reset
REQ-029 reset_n low SHALL immediately, independent of clk, force IDLE, remaining 0, o_residual 0.
REQ-030 During and after reset: o_coin_valid 0, o_return_coin 0, o_busy 0, o_done 0.
REQ-031 Reset during DISPENSE SHALL abandon the job with no o_done pulse; an in-flight coin is not counted.

Verification
REQ-032 i_balance 1700, i_coin_ready 1, no tubes empty -> coins 1000,500,100,100 on consecutive cycles, then o_done, o_residual 0.
REQ-033 i_balance 1000, i_coin_ready low 3 cycles then high -> o_return_coin 3'b100 held 4 cycles, remaining 1000 until transfer edge, then 0, o_done.
REQ-034 i_balance 0 -> no o_coin_valid, o_done in second cycle after start, o_residual 0.
REQ-035 i_balance 150 -> one 100 coin, then o_done with o_residual 50.
REQ-036 i_balance 1000, i_coin_empty 3'b100 -> coins 500,500, o_done, o_residual 0; i_coin_empty 3'b111 -> o_done, o_residual 1000.
REQ-037 i_balance 1700, reset_n low after first coin transfer -> outputs zero immediately, no o_done, new start 500 after release dispenses single 500.
